// File: rtl/led7_scan_reader_pkg.sv
// Shared constants for 7-segment read-back: active-low segment patterns (g..a),
// special output codes and the scan FSM state type.
package led7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {SCAN, DWELL, HOLD} state_t;

endpackage

// File: rtl/led7_scan_reader_if.sv
// Display bus in, decoded frame out with valid/ready handshake.
// The master side is the reader; the slave side is the display plus the frame consumer.
interface led7_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an_in;
  logic [6:0]              seg_in;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   blank_out;
  logic [NUM_DIGITS-1:0]   err_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overrun;

  modport master (
    input  an_in, seg_in, out_ready,
    output digits_out, blank_out, err_out, out_valid, overrun
  );

  modport slave (
    output an_in, seg_in, out_ready,
    input  digits_out, blank_out, err_out, out_valid, overrun
  );
endinterface

// File: rtl/led7_scan_reader_led72bin.sv
// Combinational 7-segment pattern to 4-bit code, with blank/err flags.
module led72bin
  import led7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  always_comb begin
    code  = CODE_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: begin
        code  = CODE_BLANK;
        blank = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/led7_scan_reader.sv
// Reconstructs per-digit codes from a multiplexed active-low 7-segment bus and
// hands complete frames to a consumer over valid/ready.
module led7_scan_reader
  import led7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SETTLE     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  led7_scan_reader_if.master     bus
);

  localparam int         IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [NUM_DIGITS-1:0]   a_q, a_prev, a_low;
  logic [6:0]              s_q;
  state_t                  state;
  logic [3:0]              stable_cnt;
  logic [NUM_DIGITS-1:0]   seen, seen_next;
  logic [4*NUM_DIGITS-1:0] sh_code;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_err;
  logic [4*NUM_DIGITS-1:0] frame_digits;
  logic [NUM_DIGITS-1:0]   frame_blank, frame_err;
  logic                    frame_valid, frame_overrun;
  logic                    a_ok, a_same, capture, complete, handshake;
  logic [IW-1:0]           k;
  logic [3:0]              dec_code;
  logic                    dec_blank, dec_err;

  led72bin u_dec (
    .seg   (s_q),
    .code  (dec_code),
    .blank (dec_blank),
    .err   (dec_err)
  );

  // Anode is usable only when exactly one strobe is low.
  assign a_low     = ~a_q;
  assign a_ok      = (a_low != '0) && ((a_low & (a_low - NUM_DIGITS'(1))) == '0);
  assign a_same    = (a_q == a_prev);
  assign capture   = (state == DWELL) && a_ok && a_same && (stable_cnt == SETTLE_LAST);
  assign complete  = &seen;
  assign handshake = frame_valid && bus.out_ready;

  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a_low[i]) k = IW'(i);
    end
  end

  always_comb begin
    seen_next = complete ? '0 : seen;
    if (capture) seen_next[k] = 1'b1;
  end

  // Stage 0: input registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '1;
      a_prev <= '1;
    end else begin
      a_q    <= bus.an_in;
      a_prev <= a_q;
    end
  end

  always_ff @(posedge clk) begin
    s_q <= bus.seg_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCAN;
      stable_cnt <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (a_ok) begin
            stable_cnt <= '0;
            state      <= DWELL;
          end
        end
        DWELL: begin
          if (!a_ok) begin
            state <= SCAN;
          end else if (!a_same) begin
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 4'd1;
            if (capture) state <= HOLD;
          end
        end
        HOLD: begin
          if (!a_ok) begin
            state <= SCAN;
          end else if (!a_same) begin
            stable_cnt <= '0;
            state      <= DWELL;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // Stage 1: shadow capture; validity of entries is tracked by seen
  always_ff @(posedge clk) begin
    if (capture) begin
      sh_code[{k, 2'b00} +: 4] <= dec_code;
      sh_blank[k]              <= dec_blank;
      sh_err[k]                <= dec_err;
    end
  end

  // Stage 2: frame output and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen          <= '0;
      frame_digits  <= '0;
      frame_blank   <= '0;
      frame_err     <= '0;
      frame_valid   <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      seen <= seen_next;
      if (complete) begin
        frame_digits <= sh_code;
        frame_blank  <= sh_blank;
        frame_err    <= sh_err;
        frame_valid  <= 1'b1;
        if (handshake)        frame_overrun <= 1'b0;
        else if (frame_valid) frame_overrun <= 1'b1;
      end else if (handshake) begin
        frame_valid   <= 1'b0;
        frame_overrun <= 1'b0;
      end
    end
  end

  assign bus.digits_out = frame_digits;
  assign bus.blank_out  = frame_blank;
  assign bus.err_out    = frame_err;
  assign bus.out_valid  = frame_valid;
  assign bus.overrun    = frame_overrun;

endmodule

// File: tb/tb_led7_scan_reader.sv
// Self-checking bench: dwell-level stimulus, event-scheduled frame model, per-cycle compare.
module tb_led7_scan_reader;

  localparam int ND     = 4;
  localparam int SETTLE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led7_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

  led7_scan_reader #(.NUM_DIGITS(ND), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int vcount = 0;

  typedef struct {
    int         at;
    int         k;
    logic [6:0] seg;
  } cap_t;
  cap_t capq[$];

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [ND-1:0] prev_an = '1;

  logic [3:0]      m_code [ND];
  logic [ND-1:0]   m_sblank, m_serr, m_seen;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_blank, m_err;
  logic            m_valid, m_over;

  function automatic logic [5:0] decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == pat[i]) return {4'(i), 2'b00};
    if (s == 7'h7F) return {4'hF, 2'b10};
    return {4'hE, 2'b01};
  endfunction

  function automatic int zero_pos(input logic [ND-1:0] a);
    int n = 0;
    int p = -1;
    for (int i = 0; i < ND; i++) if (!a[i]) begin n++; p = i; end
    return (n == 1) ? p : -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: captures are scheduled by the driver, frames assemble from them.
  always @(posedge clk) begin
    bit hs;
    logic [5:0] d;
    edge_n++;
    if (rst) begin
      m_seen = '0; m_digits = '0; m_blank = '0; m_err = '0;
      m_valid = 1'b0; m_over = 1'b0;
      capq.delete();
    end else begin
      hs = m_valid && bus.out_ready;
      if (&m_seen) begin
        for (int i = 0; i < ND; i++) m_digits[4*i +: 4] = m_code[i];
        m_blank = m_sblank;
        m_err   = m_serr;
        if (hs) m_over = 1'b0;
        else if (m_valid) m_over = 1'b1;
        m_valid = 1'b1;
        m_seen  = '0;
      end else if (hs) begin
        m_valid = 1'b0;
        m_over  = 1'b0;
      end
      while (capq.size() > 0 && capq[0].at <= edge_n) begin
        if (capq[0].at == edge_n) begin
          d = decode(capq[0].seg);
          m_code[capq[0].k]   = d[5:2];
          m_sblank[capq[0].k] = d[1];
          m_serr[capq[0].k]   = d[0];
          m_seen[capq[0].k]   = 1'b1;
        end
        void'(capq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("overrun", 32'(bus.overrun), 32'(m_over));
      check("digits_out", 32'(bus.digits_out), 32'(m_digits));
      check("blank_out", 32'(bus.blank_out), 32'(m_blank));
      check("err_out", 32'(bus.err_out), 32'(m_err));
      if (bus.out_valid) vcount++;
    end
  end

  // A valid, changed anode held SETTLE+1 edges is captured SETTLE+1 edges after it is first registered.
  task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input int len);
    int p;
    cap_t c;
    @(negedge clk);
    bus.an_in  = an;
    bus.seg_in = seg;
    p = zero_pos(an);
    if (p >= 0 && an != prev_an && len >= SETTLE + 1) begin
      c.at  = edge_n + 1 + SETTLE + 1;
      c.k   = p;
      c.seg = seg;
      capq.push_back(c);
    end
    prev_an = an;
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic scan_digit(input int d, input logic [6:0] seg, input int len = 5);
    drive(~(ND'(1) << d), seg, len);
  endtask

  task automatic idle(input int n);
    drive('1, 7'h7F, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.an_in = '1;
    prev_an   = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ND-1:0] an;
    logic [6:0]    sg;
    int            r;
    bus.an_in     = '1;
    bus.seg_in    = 7'h7F;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_digits", 32'(bus.digits_out), 32'h0);
    check("reset_valid", 32'(bus.out_valid), 32'h0);
    check("reset_overrun", 32'(bus.overrun), 32'h0);

    vcount = 0;
    for (int i = 0; i < 4; i++) scan_digit(i, pat[i]);
    idle(6);
    check("t1_pulses", 32'(vcount), 32'd1);
    check("t1_digits", 32'(bus.digits_out), 32'h3210);
    check("t1_blank", 32'(bus.blank_out), 32'h0);
    check("t1_err", 32'(bus.err_out), 32'h0);

    scan_digit(0, 7'b1111000);
    scan_digit(1, 7'b0101010);
    scan_digit(2, 7'b1111111);
    scan_digit(3, 7'b1111000);
    idle(6);
    check("t2_digits", 32'(bus.digits_out), 32'h7FE7);
    check("t2_blank", 32'(bus.blank_out), 32'b0100);
    check("t2_err", 32'(bus.err_out), 32'b0010);

    vcount = 0;
    scan_digit(0, pat[5]);
    scan_digit(1, pat[6]);
    scan_digit(2, pat[9], 2);
    scan_digit(3, pat[4]);
    idle(6);
    check("t3_no_frame", 32'(vcount), 32'd0);
    scan_digit(2, pat[2]);
    idle(6);
    check("t3_pulses", 32'(vcount), 32'd1);
    check("t3_digits", 32'(bus.digits_out), 32'h4265);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) scan_digit(i, pat[9]);
    for (int i = 0; i < 4; i++) scan_digit(i, pat[8]);
    idle(6);
    check("t4_valid", 32'(bus.out_valid), 32'd1);
    check("t4_digits", 32'(bus.digits_out), 32'h8888);
    check("t4_overrun", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_valid_clr", 32'(bus.out_valid), 32'd0);
    check("t4_overrun_clr", 32'(bus.overrun), 32'd0);
    bus.out_ready = 1'b1;

    vcount = 0;
    scan_digit(0, pat[9]);
    scan_digit(1, pat[8]);
    scan_digit(2, pat[7]);
    drive(4'b0011, pat[1], 10);
    drive(4'b1111, pat[1], 10);
    check("t5_no_frame", 32'(vcount), 32'd0);
    scan_digit(3, pat[6]);
    idle(6);
    check("t5_pulses", 32'(vcount), 32'd1);
    check("t5_digits", 32'(bus.digits_out), 32'h6789);

    scan_digit(0, pat[1]);
    scan_digit(1, pat[3]);
    scan_digit(2, pat[5]);
    do_reset();
    @(negedge clk);
    check("t6_rst_digits", 32'(bus.digits_out), 32'h0);
    check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    check("t6_rst_overrun", 32'(bus.overrun), 32'h0);
    vcount = 0;
    scan_digit(0, pat[1]);
    scan_digit(1, pat[3]);
    scan_digit(2, pat[5]);
    scan_digit(3, pat[7]);
    idle(6);
    check("t6_pulses", 32'(vcount), 32'd1);
    check("t6_digits", 32'(bus.digits_out), 32'h7531);

    repeat (300) begin
      do begin
        if ($urandom_range(0, 9) < 8) an = ~(ND'(1) << $urandom_range(0, ND - 1));
        else an = ND'($urandom);
      end while (an == prev_an);
      r = $urandom_range(0, 9);
      if (r < 7)       sg = pat[$urandom_range(0, 9)];
      else if (r == 7) sg = 7'h7F;
      else             sg = 7'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      drive(an, sg, $urandom_range(1, 7));
    end
    bus.out_ready = 1'b1;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led7_scan_reader.md
# led7_scan_reader

Reads back a multiplexed, active-low 7-segment display bus, the same anode-strobe and segment encoding our display drivers produce, and reconstructs the per-digit 4-bit values. It sits on the verification/self-check path beside the display driver. It presents a complete frame of digits to a consumer through a valid/ready handshake, with per-digit blank and error flags and a sticky overrun flag.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (anodes); 1..8
- SETTLE, 3, consecutive stable cycles of a registered anode value required before sampling; 1..15
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- an_in  in  NUM_DIGITS  anode strobes, active-low; exactly one bit low selects that digit
- seg_in  in  7  segments, active-low, bit6..bit0 = g,f,e,d,c,b,a
- digits_out  out  4*NUM_DIGITS  decoded codes; digit i at [4i+3:4i]
- blank_out  out  NUM_DIGITS  digit i was all segments off
- err_out  out  NUM_DIGITS  digit i had an unrecognised pattern
- out_valid  out  1  frame available; held until accepted
- out_ready  in  1  consumer accepts the frame when out_valid & out_ready
- overrun  out  1  sticky: a completed frame replaced an unaccepted one

## Operation
- Input stage: an_in and seg_in are registered once (a_q, s_q) before any use.
- Decode (pattern→code):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
  - 1111111→code 4'hF with blank bit set
  - any other pattern→code 4'hE with err bit set
- a_q is "valid" iff exactly one bit is 0. All-ones or multiple zeros count as invalid: no capture, and the FSM returns to SCAN.
- FSM:
  - SCAN: on a valid a_q, clear stable_cnt and go to DWELL.
  - DWELL: if a_q equals its previous value, stable_cnt increments. When stable_cnt reaches SETTLE, capture into digit index k (k = position of the 0 bit): shadow code/blank/err[k] ← decode(s_q), seen[k] ← 1, then go to HOLD. If a_q changes, go to SCAN on the same edge, or restart DWELL if the new value is valid.
  - HOLD: exactly one capture per dwell. On any change of a_q, behave as in SCAN.
- Recapture of an already-seen digit overwrites its shadow entry.
- Frame completion: when seen is all-ones, on the next edge:
  - shadow → output registers
  - out_valid ← 1
  - seen ← 0
- Handshake: out_valid & out_ready clears out_valid and overrun on that edge.
- Completion while out_valid=1 and out_ready=0: outputs are overwritten and overrun ← 1.
- Completion in the same cycle as a handshake: new data loads, out_valid stays 1, overrun ← 0.
- rst mid-frame discards the shadow and seen state. There is no partial-frame output.

## Timing
- Reset values: digits_out=0, blank_out=0, err_out=0, out_valid=0, overrun=0; FSM=SCAN, seen=0, stable_cnt=0.
- Capture guarantee: an_in and seg_in held constant for SETTLE+2 cycles produces exactly one capture of that digit.
- Capture latency: the capture edge is SETTLE+1 edges after the first edge that registers the new an_in.
- Output latency: out_valid rises 1 edge after the capture that completes seen.
- out_ready has no combinational path to any output.

## Structure
- Package led7_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK (active-low, g..a)
  - CODE_BLANK=4'hF and CODE_ERR=4'hE
  - the FSM state enum {SCAN, DWELL, HOLD}
- Sub-module led72bin: purely combinational pattern → {code[3:0], blank, err}, shared with other readers.
- Top level: input registers, FSM, shadow array, output/handshake logic.

## Test plan
- Scan digits 0..3 with patterns 1000000, 1111001, 0100100, 0110000, each held 5 cycles, out_ready=1 → one out_valid pulse, digits_out=16'h3210, blank_out=0, err_out=0.
- Digit 2 = 1111111, digit 1 = 0101010, others 1111000 → digits_out=16'h7FE7, blank_out=4'b0100, err_out=4'b0010.
- Anode held 2 cycles only (SETTLE=3) before switching → no capture for that digit and no out_valid until a full-length dwell occurs.
- out_ready=0 across two complete frames 9999 then 8888 → out_valid=1, digits_out=16'h8888, overrun=1. Then out_ready=1 for 1 cycle → out_valid=0, overrun=0.
- an_in=4'b0011 (two low) or 4'b1111 for 10 cycles → no capture, seen unchanged.
- rst asserted mid-frame after 3 digits, then released → all outputs 0; the next complete 4-digit scan yields exactly one frame.
